key_sched_ctrl: RTL
===================

KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 128: width of one round key and of the expansion-unit key ports.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum number of WAIT cycles allowed per expansion round.
REQ-003 SHALL have port clk, input, 1: clock.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: request to expand key_in.
REQ-006 SHALL have port key_len, input, 1: 0 = AES-128, 1 = AES-256.
REQ-007 SHALL have port key_in, input, 256: cipher key; AES-128 uses [255:128].
REQ-008 SHALL have ports busy (out, 1), done (out, 1, pulse) and err (out, 1, sticky).
REQ-009 SHALL have expansion-unit ports ke_key (out, 128), ke_prev_key (out, 128), ke_flip (out, 1), ke_rnum (out, 4), ke_key_len (out, 1), ke_valid_in (out, 1), ke_valid_out (in, 1) and ke_out_key (in, 128).
REQ-010 SHALL have round-key store write ports rk_we (out, 1), rk_addr (out, 4) and rk_data (out, 128).

Function
REQ-011 SHALL implement the states IDLE, LOAD0, LOAD1, ISSUE, WAIT, WRITE, DONE and ERR; all outputs SHALL be registered.
REQ-012 In IDLE, start=1 SHALL capture key_in and key_len into internal registers, clear err and move to LOAD0; start in any other state SHALL be ignored.
REQ-013 LOAD0 SHALL write key[255:128] to rk_addr 0.
REQ-014 LOAD0 SHALL then go to LOAD1 when key_len=1, else to ISSUE.
REQ-015 LOAD1 SHALL write key[127:0] to rk_addr 1 and then go to ISSUE.
REQ-016 The controller SHALL hold cur (the last round key written) and prev (the round key written before it).
REQ-017 After LOAD0 with key_len=0, cur SHALL be key[255:128]; prev is unused in this mode.
REQ-018 After LOAD1, prev SHALL be key[255:128] and cur SHALL be key[127:0].
REQ-019 ISSUE SHALL assert ke_valid_in for exactly 1 cycle with ke_key=cur, ke_prev_key=prev and ke_key_len=key_len, then go to WAIT.
REQ-020 Let n be the index of the round key being produced; for AES-128, n runs 1..10, ke_flip=1 and ke_rnum=n-1.
REQ-021 For AES-256, n runs 2..14; even n SHALL drive ke_flip=1 and ke_rnum=n/2-1 (values 0..6).
REQ-022 For AES-256, odd n SHALL drive ke_flip=0 and ke_rnum=(n-1)/2-1; ke_rnum is a don't-care when ke_flip=0.
REQ-023 In WAIT, a cycle with ke_valid_out=1 SHALL capture ke_out_key and move to WRITE.
REQ-024 ke_valid_out SHALL be ignored in every state other than WAIT.
REQ-025 In WAIT, a wait counter SHALL increment each cycle; reaching TIMEOUT without ke_valid_out SHALL move to ERR.
REQ-026 WRITE SHALL pulse rk_we for 1 cycle with rk_addr=n and rk_data equal to the captured key, and SHALL update prev<=cur and cur<=captured.
REQ-027 WRITE SHALL go to DONE if n equals 10 (AES-128) or 14 (AES-256), else increment n and go to ISSUE.
REQ-028 Per-round latency SHALL be L+2 cycles, where L (≥1) is the number of cycles from ke_valid_in to ke_valid_out.
REQ-029 DONE SHALL pulse done for 1 cycle and return to IDLE; a start in DONE SHALL be ignored.
REQ-030 ERR SHALL set err=1, write nothing further and return to IDLE the next cycle; err SHALL stay 1 until the next accepted start.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 rk_we SHALL be asserted only in LOAD0, LOAD1 and WRITE; rk_addr SHALL never exceed 14.

Reset
REQ-033 reset=0 SHALL asynchronously force state IDLE and clear busy, done, err, rk_we, ke_valid_in, rk_addr, rk_data, ke_key, ke_prev_key, ke_flip, ke_rnum, ke_key_len, n, the wait counter, cur and prev to 0.
REQ-034 Reset asserted mid-expansion SHALL abort the expansion with no further rk_we; after release, the controller SHALL accept a new start normally.

Verification
REQ-035 AES-128 scenario: key_in[255:128]=000102030405060708090a0b0c0d0e0f, key_len=0 -> 11 writes at addr 0..10, addr 10 data 13111d7fe3944a17f307a78b4d2b30c5, and exactly one done pulse.
REQ-036 AES-256 scenario: key_in=00010203...1e1f, key_len=1 -> 15 writes at addr 0..14, ke_flip pattern 1,0,1,0,... starting at n=2, and addr 14 data 24fc79ccbf0979e9371ac23c6d68de36.
REQ-037 Timeout scenario: ke_valid_out held at 0 -> err=1 after TIMEOUT WAIT cycles, busy=0, no done pulse, and the next start clears err.
REQ-038 Ignored-input scenario: start pulsed while busy and a stray ke_valid_out in ISSUE -> no restart, write sequence unchanged.
REQ-039 Reset scenario: reset asserted at n=5 -> all outputs read 0 immediately; a fresh AES-128 run then completes correctly.
REQ-040 Latency scenario: expansion-unit model with L=1 and then L=3 -> rk_we spacing of 3 and 5 cycles respectively.

Source files
------------

// File: rtl/key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// key_sched_ctrl
//
// Sequences an external AES key-expansion unit to produce the full set of
// round keys for AES-128 (11 keys) or AES-256 (15 keys). Each key is written
// to a round-key store. The controller keeps the last two round keys, cur and
// prev. For every round it feeds them to the expansion unit and waits for the
// result. The wait is bounded; a timeout aborts the run and raises err.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   start                 request to expand key_in (accepted only when idle)
//   key_len               0 = AES-128 (key_in[255:128] only), 1 = AES-256
//   key_in                cipher key
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse when the last round key is written
//   err                   sticky timeout flag, cleared by the next accepted start
//   ke_key, ke_prev_key   current / previous round key to the expansion unit
//   ke_flip, ke_rnum      round-type select and round-constant index
//   ke_key_len            key length forwarded to the expansion unit
//   ke_valid_in           one-cycle request strobe to the expansion unit
//   ke_valid_out          expansion result strobe (only honoured in WAIT)
//   ke_out_key            expansion result
//   rk_we, rk_addr,       round-key store write port
//   rk_data
//   state_dbg             current FSM state, for observation only
//
// Handshake: ke_valid_in is a single-cycle request. The unit answers later
// with a single-cycle ke_valid_out and ke_out_key. Only one request is ever
// outstanding.
// Every output is a register. Next values are decoded from the next state, so
// each output lines up with the state that owns it: rk_we is high exactly
// during LOAD0/LOAD1/WRITE, and ke_valid_in is high exactly during ISSUE.
// ---------------------------------------------------------------------------
module key_sched_ctrl #(
    parameter int KEY_WIDTH = 128,
    parameter int TIMEOUT   = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   key_len,
    input  logic [2*KEY_WIDTH-1:0] key_in,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [KEY_WIDTH-1:0]   ke_key,
    output logic [KEY_WIDTH-1:0]   ke_prev_key,
    output logic                   ke_flip,
    output logic [3:0]             ke_rnum,
    output logic                   ke_key_len,
    output logic                   ke_valid_in,
    input  logic                   ke_valid_out,
    input  logic [KEY_WIDTH-1:0]   ke_out_key,
    output logic                   rk_we,
    output logic [3:0]             rk_addr,
    output logic [KEY_WIDTH-1:0]   rk_data,
    output logic [2:0]             state_dbg
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD0 = 3'd1,
        S_LOAD1 = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t               state, state_d;
    logic [KEY_WIDTH-1:0] key_lo, key_lo_d;
    logic                 len_r, len_d;
    logic [3:0]           n, n_d;
    logic [CW-1:0]        wait_cnt, wait_d, wait_inc;
    logic [KEY_WIDTH-1:0] cur, cur_d;
    logic [KEY_WIDTH-1:0] prev, prev_d;
    logic [KEY_WIDTH-1:0] cap, cap_d;
    logic [3:0]           last_n;

    logic                 busy_d, done_d, err_d;
    logic                 rk_we_d;
    logic [3:0]           rk_addr_d;
    logic [KEY_WIDTH-1:0] rk_data_d;
    logic [KEY_WIDTH-1:0] ke_key_d, ke_prev_key_d;
    logic                 ke_flip_d, ke_key_len_d, ke_valid_in_d;
    logic [3:0]           ke_rnum_d;

    assign last_n    = len_r ? 4'd14 : 4'd10;
    assign wait_inc  = wait_cnt + CW'(1);
    assign state_dbg = state;

    // Next-state and datapath-update logic.
    always_comb begin
        state_d  = state;
        key_lo_d = key_lo;
        len_d    = len_r;
        n_d      = n;
        wait_d   = wait_cnt;
        cur_d    = cur;
        prev_d   = prev;
        cap_d    = cap;
        err_d    = err;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD0;
                    key_lo_d = key_in[KEY_WIDTH-1:0];
                    len_d    = key_len;
                    err_d    = 1'b0;
                    cur_d    = key_in[2*KEY_WIDTH-1:KEY_WIDTH];
                    prev_d   = '0;
                    // Keys 0 (and 1 for AES-256) come straight from the cipher
                    // key, so expansion starts at the first derived index.
                    n_d      = key_len ? 4'd2 : 4'd1;
                    wait_d   = '0;
                end
            end
            S_LOAD0: begin
                if (len_r) begin
                    state_d = S_LOAD1;
                    prev_d  = cur;
                    cur_d   = key_lo;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_LOAD1: state_d = S_ISSUE;
            S_ISSUE: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                if (ke_valid_out) begin
                    cap_d   = ke_out_key;
                    state_d = S_WRITE;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == CW'(TIMEOUT)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                prev_d = cur;
                cur_d  = cap;
                if (n == last_n) begin
                    state_d = S_DONE;
                end else begin
                    n_d     = n + 4'd1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state, so registered outputs coincide
    // with the state they belong to.
    always_comb begin
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE);
        ke_valid_in_d = (state_d == S_ISSUE);
        rk_we_d       = 1'b0;
        rk_addr_d     = rk_addr;
        rk_data_d     = rk_data;
        ke_key_d      = ke_key;
        ke_prev_key_d = ke_prev_key;
        ke_flip_d     = ke_flip;
        ke_rnum_d     = ke_rnum;
        ke_key_len_d  = ke_key_len;

        case (state_d)
            S_LOAD0: begin
                rk_we_d   = 1'b1;
                rk_addr_d = 4'd0;
                rk_data_d = cur_d;
            end
            S_LOAD1: begin
                rk_we_d   = 1'b1;
                rk_addr_d = 4'd1;
                rk_data_d = cur_d;
            end
            S_WRITE: begin
                rk_we_d   = 1'b1;
                rk_addr_d = n_d;
                rk_data_d = cap_d;
            end
            S_ISSUE: begin
                ke_key_d      = cur_d;
                ke_prev_key_d = prev_d;
                ke_key_len_d  = len_d;
                // AES-256 alternates round types: even n uses RotWord+Rcon,
                // odd n is SubWord only. n/2-1 equals (n-1)/2-1 for odd n, so
                // one expression serves both.
                if (len_d) begin
                    ke_flip_d = ~n_d[0];
                    ke_rnum_d = {1'b0, n_d[3:1]} - 4'd1;
                end else begin
                    ke_flip_d = 1'b1;
                    ke_rnum_d = n_d - 4'd1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            key_lo      <= '0;
            len_r       <= 1'b0;
            n           <= '0;
            wait_cnt    <= '0;
            cur         <= '0;
            prev        <= '0;
            cap         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            rk_we       <= 1'b0;
            rk_addr     <= '0;
            rk_data     <= '0;
            ke_key      <= '0;
            ke_prev_key <= '0;
            ke_flip     <= 1'b0;
            ke_rnum     <= '0;
            ke_key_len  <= 1'b0;
            ke_valid_in <= 1'b0;
        end else begin
            state       <= state_d;
            key_lo      <= key_lo_d;
            len_r       <= len_d;
            n           <= n_d;
            wait_cnt    <= wait_d;
            cur         <= cur_d;
            prev        <= prev_d;
            cap         <= cap_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            rk_we       <= rk_we_d;
            rk_addr     <= rk_addr_d;
            rk_data     <= rk_data_d;
            ke_key      <= ke_key_d;
            ke_prev_key <= ke_prev_key_d;
            ke_flip     <= ke_flip_d;
            ke_rnum     <= ke_rnum_d;
            ke_key_len  <= ke_key_len_d;
            ke_valid_in <= ke_valid_in_d;
        end
    end

endmodule
